// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and queue entry type for the LEGv8 fetch front end
package fetch_pkg;
  localparam int N = 64;
  localparam int IW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 2;
  localparam logic [N-1:0] PC_INC = N'(4);
  localparam logic [N-1:0] RESET_PC = '0;
  typedef struct packed {
    logic [N-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched words with a registered head that holds when empty
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  fetch_entry_t head_q, head_d;
  logic wr_q, wr_d, rd_q, rd_d, do_pop, do_push;
  logic [1:0] cnt_q, cnt_d;
  assign full = cnt_q == 2'(DEPTH);
  assign empty = cnt_q == 2'd0;
  assign head = head_q;
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = flush ? 1'b0 : wr_q ^ do_push;
    rd_d = flush ? 1'b0 : rd_q ^ do_pop;
    cnt_d = flush ? 2'd0 : cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    head_d = (cnt_d != 2'd0) ? mem_d[rd_d] : head_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      head_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, ROM addressing and redirect handling feeding a 2-entry fetch queue
module fetch_unit
  import fetch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [N-1:0]  instr_pc
);
  logic [N-1:0] pc_q, pc_d;
  logic full, empty, pop, fetch_en;
  fetch_entry_t din, head;
  assign pop = instr_valid & instr_ready;
  assign din.pc = pc_q;
  assign din.instr = imem_q;
  assign imem_addr = pc_q[AW+1:2];
  assign instr_valid = ~empty;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_comb begin
    fetch_en = ~redirect_valid & (~full | pop);
    pc_d = redirect_valid ? (redirect_pc & ~N'(3)) : fetch_en ? pc_q + PC_INC : pc_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  fetch_queue u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the LEGv8 processor.
- Owns the PC and drives the word address of the 64x32 instruction ROM, which it reads combinationally.
- Buffers fetched words with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the queue.

Parameters:
- N, 64, PC and redirect address width.
- IW, 32, instruction width (matches the ROM data width).
- AW, 6, ROM word-address width; ROM depth is 2**AW.
- DEPTH, 2, fetch queue entries (fixed at 2; other values unsupported).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  AW  ROM word address, equal to pc[AW+1:2].
- imem_q  in  IW  ROM data for imem_addr, same cycle (combinational ROM).
- redirect_valid  in  1  redirect request from execute.
- redirect_pc  in  N  redirect target byte address.
- instr_valid  out  1  queue head holds a valid instruction.
- instr_ready  in  1  decode accepts the head this cycle.
- instr  out  IW  head instruction word.
- instr_pc  out  N  byte PC of the head instruction.

Behaviour:
- Reset (async, active-high): pc=0, queue count=0, head/tail pointers=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=0.
  - Reset asserted mid-operation discards all queued entries and any pending redirect immediately.
- Address mapping: imem_addr = pc[AW+1:2]. pc[1:0] is always 0. Bits above AW+1 are ignored, so fetch wraps modulo 2**(AW+2) = 256 bytes.
- pop = instr_valid & instr_ready.
- fetch_en = !redirect_valid & (count < DEPTH | pop).
  - A full queue can still accept a word in the same cycle it is popped.
- When fetch_en is set, at the clock edge:
  - push {pc, imem_q} at the tail.
  - pc <= pc + 4, N-bit wrap.
- When fetch_en is clear and there is no redirect: pc holds, so imem_addr is stable while stalled.
- Redirect (redirect_valid=1) has priority over push and pop. At the edge:
  - queue count <= 0, pointers <= 0, instr_valid <= 0.
  - pc <= {redirect_pc[N-1:2], 2'b00}; misaligned targets are silently aligned down.
  - A pop handshake in the same cycle counts as accepted by decode; the popped entry is still discarded by the flush.
- Latency:
  - First instruction valid at the first edge after reset deasserts: 1 cycle ROM-to-output.
  - Redirect-to-valid-target: 2 edges (flush edge, then fetch edge).
- Throughput: 1 instruction/cycle sustained while instr_ready=1.
- Outputs instr_valid, instr and instr_pc come from queue storage (registered), never combinationally from imem_q.
- When empty, instr and instr_pc hold their last values. Decode must qualify them with instr_valid.
- Ordering: strict FIFO. No drop or duplication under any pattern of instr_ready.
- count = 0..DEPTH. Pointers are 1 bit each and wrap.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t = struct {logic [N-1:0] pc; logic [IW-1:0] instr}.
  - localparams PC_INC=4 and RESET_PC=0.
- One natural sub-module: fetch_queue.
  - 2-entry synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Same clk/reset.
- fetch_unit contains the PC register, the fetch_en/redirect logic, and the fetch_queue instance.

Test Plan:
1. Reset, then instr_ready=1 with the program image loaded (words 0..2 = f8000001, f8008002, f8000203) -> at edges 1, 2, 3 the head is (pc 0x0, f8000001), (0x4, f8008002), (0x8, f8000203); instr_valid stays 1.
2. instr_ready=0 for 5 cycles after first valid -> count saturates at 2, imem_addr holds 2, head stays (0x0, f8000001); release -> 0x0, 0x4, 0x8 delivered on consecutive cycles, none lost or repeated.
3. Full queue with instr_ready=1 held -> push and pop every cycle, count stays 2, pc increments by 4 per cycle.
4. redirect_valid=1, redirect_pc=0x74 while 2 entries queued and instr_ready=1 -> next edge instr_valid=0; following edge head is (0x74, b4000040); old entries never reappear.
5. redirect_pc=0x7 -> pc becomes 0x4, imem_addr 1, head (0x4, f8008002). redirect_pc=0xFC -> fetch addr 63 then addr 0 (pc 0x100): head pcs 0xFC then 0x100, the second carrying word 0 (f8000001).
6. Reset asserted asynchronously mid-cycle with count=2 -> instr_valid drops immediately without a clock edge; after release the first valid is pc 0x0 with f8000001.
